// File: rtl/aes_128_inv_iter.sv
// rtl/aes_128_inv_iter.sv - iterative AES-128 inverse cipher, one round per clock
// Optional key cache skips the forward key expansion when the same key repeats.
module aes_128_inv_iter #(
  parameter int KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] ct,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  state_t       state, state_d;
  logic [127:0] s_reg, k_reg, key_cache, k10_cache;
  logic         cache_valid;
  logic [3:0]   rnd;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, r;
    p = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Undo one expansion step: recover the previous round key from the next one.
  function automatic logic [127:0] inv_expand(input logic [127:0] n, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = n[31:0] ^ n[63:32];
    w2 = n[63:32] ^ n[95:64];
    w1 = n[95:64] ^ n[127:96];
    w0 = n[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      src = 4 * (((b / 4) - (b % 4) + 4) % 4) + (b % 4);
      o[127-8*b -: 8] = inv_sbox(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic         accept, hit;
  logic [127:0] k_fwd, k_prev, t;

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign hit      = (KEY_CACHE != 0) && cache_valid && (key == key_cache);
  assign k_fwd    = fwd_expand(k_reg, rcon(rnd));
  assign k_prev   = inv_expand(k_reg, rcon(rnd + 4'd1));
  assign t        = inv_shift_sub(s_reg) ^ k_prev;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = hit ? ROUND : KEYEXP;
      KEYEXP:  if (rnd == 4'd10) state_d = ROUND;
      ROUND:   if (rnd == 4'd0) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg       <= '0;
      k_reg       <= '0;
      key_cache   <= '0;
      k10_cache   <= '0;
      cache_valid <= 1'b0;
      rnd         <= 4'd0;
      pt          <= '0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (hit) begin
              k_reg <= k10_cache;
              s_reg <= ct ^ k10_cache;
              rnd   <= 4'd9;
            end else begin
              k_reg       <= key;
              s_reg       <= ct;
              rnd         <= 4'd1;
              key_cache   <= key;
              cache_valid <= 1'b0;
            end
          end
        end
        KEYEXP: begin
          k_reg <= k_fwd;
          if (rnd == 4'd10) begin
            s_reg       <= s_reg ^ k_fwd;
            k10_cache   <= k_fwd;
            cache_valid <= (KEY_CACHE != 0);
            rnd         <= 4'd9;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        ROUND: begin
          k_reg <= k_prev;
          s_reg <= (rnd != 4'd0) ? inv_mix(t) : t;
          if (rnd == 4'd0) begin
            pt        <= t;
            out_valid <= 1'b1;
          end else begin
            rnd <= rnd - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_inv_iter.sv
// tb/tb_aes_128_inv_iter.sv - scoreboard bench for aes_128_inv_iter
// Expected plaintexts come from FIPS-197 vectors and a table-driven forward-cipher model.
module tb_aes_128_inv_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] key_in, ct_in, pt;
  logic         nc_in_valid, nc_in_ready, nc_out_valid, nc_out_ready, nc_busy;
  logic [127:0] nc_key, nc_ct, nc_pt;

  always #5 clk = ~clk;

  aes_128_inv_iter #(.KEY_CACHE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key(key_in), .ct(ct_in),
    .out_valid(out_valid), .out_ready(out_ready), .pt(pt), .busy(busy)
  );

  aes_128_inv_iter #(.KEY_CACHE(0)) dut_nc (
    .clk(clk), .rst(rst), .in_valid(nc_in_valid), .in_ready(nc_in_ready), .key(nc_key), .ct(nc_ct),
    .out_valid(nc_out_valid), .out_ready(nc_out_ready), .pt(nc_pt), .busy(nc_busy)
  );

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [7:0]   sb [256];
  logic         mc_valid;
  logic [127:0] mc_key, last_key, r_key, r_pt;
  logic         holding = 1'b0;
  logic         drop_chk = 1'b0;
  logic [127:0] hold_pt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] p_in, input logic [127:0] k_in);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k_in[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int b = 0; b < 16; b++) s[b] = p_in[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) u[b] = sb[s[4*(((b/4) + (b%4)) % 4) + (b%4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        if (r < 10) begin
          u[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          u[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          u[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          u[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int b = 0; b < 16; b++) s[b] = u[b] ^ w[4*r + b/4][31-8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
    return res;
  endfunction

  task automatic push(input logic [127:0] k, input logic [127:0] p);
    exp_t e;
    e.pt  = p;
    e.acc = cyc + 1;
    e.lat = (mc_valid && k == mc_key) ? 11 : 21;
    mc_valid = 1'b1;
    mc_key   = k;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    int n = 0;
    key_in = k;
    ct_in = c;
    in_valid = 1'b1;
    while (!in_ready && n < 300) begin tick(); n++; end
    if (n >= 300) chk("send_timeout", 1, 0);
    else push(k, p);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb_q.size() != 0) && n < 300) begin tick(); n++; end
    if (n >= 300) chk("idle_timeout", 1, 0);
  endtask

  task automatic nc_run(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    int n = 0;
    int acc;
    nc_key = k;
    nc_ct = c;
    nc_in_valid = 1'b1;
    while (!nc_in_ready && n < 100) begin tick(); n++; end
    acc = cyc + 1;
    tick();
    nc_in_valid = 1'b0;
    n = 0;
    while (!nc_out_valid && n < 100) begin tick(); n++; end
    chk("nocache_latency", 128'(cyc + 1 - acc), 128'(21));
    chk("nocache_pt", nc_pt, p);
    tick();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      holding  = 1'b0;
      drop_chk = 1'b0;
    end else begin
      if (drop_chk) begin
        chk("release_out_valid", 128'(out_valid), 128'(0));
        chk("release_in_ready", 128'(in_ready), 128'(1));
        drop_chk = 1'b0;
      end
      if (out_valid) begin
        if (!holding) begin
          if (sb_q.size() == 0) begin
            chk("spurious_out_valid", 1, 0);
          end else begin
            mon_e = sb_q.pop_front();
            chk("pt", pt, mon_e.pt);
            chk("latency", 128'(cyc + 1 - mon_e.acc), 128'(mon_e.lat));
          end
          hold_pt = pt;
          holding = 1'b1;
        end else begin
          chk("pt_stable", pt, hold_pt);
        end
        chk("in_ready_in_done", 128'(in_ready), 128'(0));
        if (out_ready) begin
          holding  = 1'b0;
          drop_chk = 1'b1;
        end
      end
    end
  end

  initial begin
    int sent, guard, n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; key_in = '0; ct_in = '0;
    nc_in_valid = 1'b0; nc_out_ready = 1'b1; nc_key = '0; nc_ct = '0;
    mc_valid = 1'b0; mc_key = '0; last_key = K1;
    build_sbox();
    repeat (3) tick();
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_pt", pt, 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", 128'(in_ready), 128'(1));
    tick();

    send(K1, C1, P1);
    wait_idle();
    r_pt = {$urandom, $urandom, $urandom, $urandom};
    send(K1, aes_enc(r_pt, K1), r_pt);
    wait_idle();
    send(K2, C2, P2);
    wait_idle();

    out_ready = 1'b0;
    r_key = {$urandom, $urandom, $urandom, $urandom};
    r_pt  = {$urandom, $urandom, $urandom, $urandom};
    send(r_key, aes_enc(r_pt, r_key), r_pt);
    n = 0;
    while (!out_valid && n < 60) begin tick(); n++; end
    repeat (50) tick();
    chk("backpressure_out_valid", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    tick();
    wait_idle();

    send(K2, C2, P2);
    repeat (14) tick();
    rst = 1'b1;
    sb_q.delete();
    mc_valid = 1'b0;
    tick();
    chk("midrun_reset_out_valid", 128'(out_valid), 128'(0));
    chk("midrun_reset_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    #1;
    chk("midrun_release_in_ready", 128'(in_ready), 128'(1));
    tick();
    send(K2, C2, P2);
    wait_idle();

    nc_run(K1, C1, P1);
    nc_run(K1, C1, P1);

    sent = 0;
    guard = 0;
    while (sent < 1000 && guard < 80000) begin
      tick();
      guard++;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = $urandom_range(0, 1);
      if (in_valid) begin
        r_key = ($urandom_range(0, 3) == 0) ? last_key : {$urandom, $urandom, $urandom, $urandom};
        r_pt  = {$urandom, $urandom, $urandom, $urandom};
        last_key = r_key;
        key_in = r_key;
        ct_in  = aes_enc(r_pt, r_key);
        if (in_ready) begin
          push(r_key, r_pt);
          sent++;
        end
      end
    end
    if (sent < 1000) chk("random_budget", 128'(sent), 128'(1000));
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
